// File: rtl/dr_pkg.sv
// Shared types and helpers for the four-phase dual-rail link.
package dr_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    RTZ
  } state_t;

  localparam int RAIL_T   = 1;
  localparam int RAIL_F   = 0;
  localparam int RAIL_NUM = 2;

  // One data bit onto its rail pair: exactly one rail high.
  function automatic logic [RAIL_NUM-1:0] dr_encode(input logic b);
    logic [RAIL_NUM-1:0] c;
    c         = '0;
    c[RAIL_T] = b;
    c[RAIL_F] = ~b;
    return c;
  endfunction

endpackage

// File: rtl/dr_tx_if.sv
// Producer handshake plus dual-rail link between producer, transmitter and receiver.
interface dr_tx_if
  import dr_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]               in_data;
  logic                           in_valid;
  logic                           in_ready;
  logic [WIDTH-1:0][RAIL_NUM-1:0] out;
  logic                           ack;

  modport master (output in_data, in_valid, ack, input in_ready, out);
  modport slave  (input in_data, in_valid, ack, output in_ready, out);

endinterface

// File: rtl/sync_ff.sv
// Multi-stage flop chain bringing an asynchronous level into the clk domain.
module sync_ff #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  // Shift the asynchronous level through the chain; the last stage is safe to use.
  always_ff @(posedge clk) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/dr_tx.sv
// Clocked transmitter for the four-phase dual-rail link (return-to-zero).
module dr_tx
  import dr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic    clk,
  input  logic    rst,
  dr_tx_if.slave  link,
  output logic    busy,
  output logic    err
);

  state_t state, state_n;
  logic [WIDTH-1:0][RAIL_NUM-1:0] out_q, out_n;
  logic in_ready_q, in_ready_n;
  logic ack_s;
  logic ready_ok;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (link.ack),
    .q   (ack_s)
  );

  // The ack synchroniser reads 0 for SYNC_STAGES cycles after reset whatever
  // the real ack is; a constant pushed through an identical chain marks when
  // ack_s becomes trustworthy, so a still-high ack cannot be mistaken for low.
  sync_ff #(.STAGES(SYNC_STAGES)) u_warm (
    .clk (clk),
    .rst (rst),
    .d   (1'b1),
    .q   (ready_ok)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n    = state;
    out_n      = out_q;
    in_ready_n = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_n = ready_ok && !ack_s;
        if (link.in_valid && in_ready_q) begin
          state_n    = DATA;
          in_ready_n = 1'b0;
          for (int unsigned i = 0; i < WIDTH; i++) out_n[i] = dr_encode(link.in_data[i]);
        end
      end
      DATA: begin
        if (ack_s) begin
          state_n = RTZ;
          out_n   = '0;
        end
      end
      RTZ: begin
        if (!ack_s) begin
          state_n    = IDLE;
          in_ready_n = ready_ok;
        end
      end
      default: begin
        state_n = IDLE;
        out_n   = '0;
      end
    endcase
  end

  // Output registers: the link rails come straight from flops so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q      <= '0;
      in_ready_q <= 1'b0;
      busy       <= 1'b0;
    end else begin
      out_q      <= out_n;
      in_ready_q <= in_ready_n;
      busy       <= (state_n != IDLE);
    end
  end

  assign link.out      = out_q;
  assign link.in_ready = in_ready_q;

  if (TIMEOUT > 0) begin : g_wd
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    logic [CW-1:0] cnt;

    // Watchdog: restart on every state entry, count while handshaking, saturate; err is sticky.
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt <= '0;
        err <= 1'b0;
      end else begin
        if (state_n != state) begin
          cnt <= '0;
        end else if (state != IDLE && cnt != CW'(TIMEOUT)) begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(TIMEOUT - 1)) err <= 1'b1;
        end
      end
    end
  end else begin : g_no_wd
    assign err = 1'b0;
  end

endmodule

// File: tb/tb_dr_tx.sv
// Scoreboarded bench for dr_tx with a behavioural dual-rail receiver.
`timescale 1ns/1ps
module tb_dr_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  bit  rx_en   = 1'b0;
  bit  rx_rand = 1'b0;
  int  rx_dly  = 3;
  int  rx_cnt  = 0;
  int  rx_words = 0;
  bit  mon_en  = 1'b0;
  logic [15:0] prev_out = '0;

  dr_tx_if #(.WIDTH(8)) link ();

  dr_tx #(.WIDTH(8), .SYNC_STAGES(2), .TIMEOUT(10)) dut (
    .clk  (clk),
    .rst  (rst),
    .link (link.slave),
    .busy (busy),
    .err  (err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] enc(input logic [7:0] d);
    logic [15:0] r;
    for (int i = 0; i < 8; i++) begin
      r[2*i+1] = d[i];
      r[2*i]   = ~d[i];
    end
    return r;
  endfunction

  function automatic bit complete(input logic [15:0] o);
    bit c = 1'b1;
    for (int i = 0; i < 8; i++)
      if (!((o[2*i+1] === 1'b1 && o[2*i] === 1'b0) || (o[2*i+1] === 1'b0 && o[2*i] === 1'b1))) c = 1'b0;
    return c;
  endfunction

  function automatic logic [7:0] decode(input logic [15:0] o);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = o[2*i+1];
    return w;
  endfunction

  // Behavioural receiver: completion detect, delayed ack, NULL detect, delayed release.
  always @(negedge clk) begin
    logic [15:0] o;
    logic [7:0]  w, e;
    o = link.out;
    if (rst || !rx_en) begin
      rx_cnt = 0;
    end else if (link.ack === 1'b0) begin
      if (complete(o)) begin
        if (rx_cnt >= rx_dly) begin
          w = decode(o);
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rx_word: received %h with nothing expected", w);
          end else begin
            e = exp_q.pop_front();
            if (w !== e) begin
              errors++;
              $display("FAIL rx_word: got %h expected %h", w, e);
            end
          end
          rx_words++;
          link.ack = 1'b1;
          rx_cnt   = 0;
          rx_dly   = rx_rand ? int'($urandom_range(0, 6)) : 3;
        end else rx_cnt++;
      end else rx_cnt = 0;
    end else begin
      if (o == '0) begin
        if (rx_cnt >= rx_dly) begin
          link.ack = 1'b0;
          rx_cnt   = 0;
          rx_dly   = rx_rand ? int'($urandom_range(0, 6)) : 3;
        end else rx_cnt++;
      end else rx_cnt = 0;
    end
  end

  // Rail monitor: never both rails high, never a direct swap between codewords.
  always @(negedge clk) begin
    logic [15:0] o;
    o = link.out;
    if (mon_en) begin
      for (int i = 0; i < 8; i++) begin
        logic [1:0] c, p;
        c = o[2*i +: 2];
        p = prev_out[2*i +: 2];
        checks++;
        if (c === 2'b11 || (p != 2'b00 && c != 2'b00 && c != p)) begin
          errors++;
          $display("FAIL rail_bit%0d: went %b -> %b, required NULL<->one rail", i, p, c);
        end
      end
    end
    prev_out = o;
  end

  task automatic do_reset(input logic ack_level);
    rx_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    link.ack = ack_level;
    link.in_valid = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    link.in_valid = 1'b1;
    link.in_data  = d;
    while (link.in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (link.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_wait: in_ready=%b after %0d cycles, required 1", link.in_ready, n);
      link.in_valid = 1'b0;
      return;
    end
    exp_q.push_back(d);
    @(posedge clk);
    #1;
    link.in_valid = 1'b0;
    link.in_data  = 8'($urandom);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || link.ack !== 1'b0 || busy !== 1'b0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drain: pending=%0d busy=%b, required 0 and 0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    link.ack = 1'b0;
    link.in_valid = 1'b0;
    link.in_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    checks++;
    if (link.out !== '0 || link.in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: out=%h in_ready=%b busy=%b err=%b, required 0 0 0 0",
               link.out, link.in_ready, busy, err);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] o;
    send(8'hA5);
    o = link.out;
    checks++;
    if (o !== 16'h9966 || link.in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept_a5: out=%h in_ready=%b busy=%b, required 9966 0 1", o, link.in_ready, busy);
    end
    repeat (2) @(posedge clk);
    #1;
    o = link.out;
    checks++;
    if (o !== 16'h9966) begin
      errors++;
      $display("FAIL hold_after_accept: out=%h required 9966", o);
    end
    @(negedge clk);
    link.ack = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      o = link.out;
      checks++;
      if (o !== ((k == 3) ? 16'h0000 : 16'h9966)) begin
        errors++;
        $display("FAIL null_latency_edge%0d: out=%h required %h", k, o, (k == 3) ? 16'h0000 : 16'h9966);
      end
    end
    @(negedge clk);
    link.ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link.in_ready !== (k == 3) || busy !== (k != 3)) begin
        errors++;
        $display("FAIL rtz_release_edge%0d: in_ready=%b busy=%b required %b %b",
                 k, link.in_ready, busy, k == 3, k != 3);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int start = rx_words;
    rx_rand = 1'b0;
    rx_dly  = 3;
    rx_en   = 1'b1;
    send(8'h00);
    send(8'hFF);
    send(8'h3C);
    wait_drain();
    checks++;
    if (rx_words - start !== 3) begin
      errors++;
      $display("FAIL b2b_count: received %0d words, required 3", rx_words - start);
    end
    rx_en = 1'b0;
  endtask

  task automatic test_ack_high();
    do_reset(1'b1);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link.in_ready !== 1'b0 || err !== 1'b0) begin
        errors++;
        $display("FAIL ack_high_idle%0d: in_ready=%b err=%b required 0 0", k, link.in_ready, err);
      end
    end
    @(negedge clk);
    link.ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link.in_ready !== (k == 3)) begin
        errors++;
        $display("FAIL ack_drop_edge%0d: in_ready=%b required %b", k, link.in_ready, k == 3);
      end
    end
  endtask

  task automatic test_timeout();
    logic [15:0] o;
    send(8'h5A);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      o = link.out;
      checks++;
      if (err !== (k == 10) || o !== enc(8'h5A)) begin
        errors++;
        $display("FAIL watchdog_edge%0d: err=%b out=%h required %b %h", k, err, o, k == 10, enc(8'h5A));
      end
    end
    @(negedge clk);
    link.ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (link.out !== '0 || err !== 1'b1) begin
      errors++;
      $display("FAIL late_ack: out=%h err=%b required 0000 1", link.out, err);
    end
    @(negedge clk);
    link.ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (link.in_ready !== 1'b1 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL after_timeout: in_ready=%b busy=%b err=%b required 1 0 1", link.in_ready, busy, err);
    end
    exp_q.delete();
  endtask

  task automatic test_rst_mid();
    do_reset(1'b0);
    send(8'hC3);
    @(negedge clk);
    link.ack = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (link.out !== '0 || busy !== 1'b0 || link.in_ready !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: out=%h busy=%b in_ready=%b err=%b required 0 0 0 0",
               link.out, busy, link.in_ready, err);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack_held%0d: in_ready=%b required 0", k, link.in_ready);
      end
    end
    @(negedge clk);
    link.ack = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      checks++;
      if (link.in_ready !== (k == 3)) begin
        errors++;
        $display("FAIL rst_ack_drop_edge%0d: in_ready=%b required %b", k, link.in_ready, k == 3);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_random();
    int start;
    do_reset(1'b0);
    start   = rx_words;
    rx_rand = 1'b1;
    rx_dly  = int'($urandom_range(0, 6));
    rx_en   = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(8'($urandom));
    end
    wait_drain();
    checks++;
    if (rx_words - start !== 1000) begin
      errors++;
      $display("FAIL random_count: received %0d words, required 1000", rx_words - start);
    end
    rx_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_ack_high();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
